// File: rtl/seq_prefix_add_ctrl.sv
// seq_prefix_add_ctrl
// Multi-cycle wide adder. It adds two WIDTH-bit operands one CHUNK-bit slice
// per clock, least-significant slice first, and reuses a single slice-wide
// generate/propagate datapath. Between slices it carries the inter-slice
// carry and the running group propagate/generate.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_valid / in_ready   operand handshake (a, b, cin)
//   out_valid / out_ready result handshake (sum, cout, grp_p, grp_g)
//   sum, cout             registered WIDTH-bit sum and carry-out
//   grp_p, grp_g          group propagate / generate over all WIDTH bits
//   busy                  high whenever the controller is not idle
module seq_prefix_add_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_width_chk
    $error("seq_prefix_add_ctrl: WIDTH must be an integer multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] a_r, b_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry, p_acc, g_acc;
  logic             cout_r, grp_p_r, grp_g_r;

  // Current slice operands and slice datapath results
  logic [CHUNK-1:0] a_s, b_s, s_s;
  logic             p_slc, g_slc, c_slc, c_bit, pk, gk;
  logic             last_slc;

  assign last_slc = (idx == IDX_W'(NCHUNK - 1));

  always_comb begin
    a_s = '0;
    b_s = '0;
    for (int j = 0; j < NCHUNK; j++) begin
      if (idx == IDX_W'(j)) begin
        a_s = a_r[j*CHUNK +: CHUNK];
        b_s = b_r[j*CHUNK +: CHUNK];
      end
    end
  end

  // In-slice prefix: the group terms exclude the incoming carry so they can be
  // folded into the running accumulators; the bit-level carry rides along to
  // form the sum bits.
  always_comb begin
    s_s   = '0;
    g_slc = 1'b0;
    p_slc = 1'b1;
    c_bit = carry;
    pk    = 1'b0;
    gk    = 1'b0;
    for (int k = 0; k < CHUNK; k++) begin
      pk     = a_s[k] ^ b_s[k];
      gk     = a_s[k] & b_s[k];
      s_s[k] = pk ^ c_bit;
      c_bit  = gk | (pk & c_bit);
      g_slc  = gk | (pk & g_slc);
      p_slc  = pk & p_slc;
    end
    c_slc = g_slc | (p_slc & carry);
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    case (state)
      IDLE:    if (in_valid) state_nxt = RUN;
      RUN:     if (last_slc) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      idx     <= '0;
      carry   <= 1'b0;
      p_acc   <= 1'b0;
      g_acc   <= 1'b0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      grp_p_r <= 1'b0;
      grp_g_r <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            carry <= cin;
            p_acc <= 1'b1;
            g_acc <= 1'b0;
            idx   <= '0;
          end
        end
        RUN: begin
          for (int j = 0; j < NCHUNK; j++) begin
            if (idx == IDX_W'(j)) sum_r[j*CHUNK +: CHUNK] <= s_s;
          end
          carry <= c_slc;
          g_acc <= g_slc | (g_acc & p_slc);
          p_acc <= p_acc & p_slc;
          if (last_slc) begin
            idx     <= '0;
            cout_r  <= c_slc;
            grp_g_r <= g_slc | (g_acc & p_slc);
            grp_p_r <= p_acc & p_slc;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Operand capture (data only, no reset)
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_r <= a;
      b_r <= b;
    end
  end

  assign sum   = sum_r;
  assign cout  = cout_r;
  assign grp_p = grp_p_r;
  assign grp_g = grp_g_r;

endmodule

// File: tb/tb_seq_prefix_add_ctrl.sv
// tb_seq_prefix_add_ctrl
// Drives three instances (CHUNK = 1, 4, 32 at WIDTH = 32) from shared operand
// and handshake inputs and checks directed vectors plus a random regression.
module tb_seq_prefix_add_ctrl;

  localparam int W = 32;
  localparam int NCH [3] = '{32, 8, 1};

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, out_ready, cin;
  logic [W-1:0]  a, b;
  logic          in_rdy [3];
  logic          out_vld [3];
  logic [W-1:0]  sum_v [3];
  logic          cout_v [3];
  logic          gp_v [3];
  logic          gg_v [3];
  logic          busy_v [3];

  int n_chk  = 0;
  int n_fail = 0;
  int lat [3];

  always #5 clk = ~clk;

  seq_prefix_add_ctrl #(.WIDTH(W), .CHUNK(1)) u_c1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[0]),
    .a(a), .b(b), .cin(cin), .out_valid(out_vld[0]), .out_ready(out_ready),
    .sum(sum_v[0]), .cout(cout_v[0]), .grp_p(gp_v[0]), .grp_g(gg_v[0]),
    .busy(busy_v[0]));

  seq_prefix_add_ctrl #(.WIDTH(W), .CHUNK(4)) u_c4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[1]),
    .a(a), .b(b), .cin(cin), .out_valid(out_vld[1]), .out_ready(out_ready),
    .sum(sum_v[1]), .cout(cout_v[1]), .grp_p(gp_v[1]), .grp_g(gg_v[1]),
    .busy(busy_v[1]));

  seq_prefix_add_ctrl #(.WIDTH(W), .CHUNK(32)) u_c32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_rdy[2]),
    .a(a), .b(b), .cin(cin), .out_valid(out_vld[2]), .out_ready(out_ready),
    .sum(sum_v[2]), .cout(cout_v[2]), .grp_p(gp_v[2]), .grp_g(gg_v[2]),
    .busy(busy_v[2]));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Present an operand set for one cycle; all instances must be idle.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Count cycles after the accepting edge until each out_valid is seen.
  task automatic wait_done();
    bit all_seen;
    for (int i = 0; i < 3; i++) lat[i] = -1;
    all_seen = 1'b0;
    for (int c = 1; c <= 40 && !all_seen; c++) begin
      @(posedge clk);
      @(negedge clk);
      all_seen = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (lat[i] < 0 && out_vld[i]) lat[i] = c;
        if (lat[i] < 0) all_seen = 1'b0;
      end
    end
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  // Golden a+b+cin model plus group terms derived from integer addition.
  task automatic check_res(input string tag, input logic [W-1:0] ta,
                           input logic [W-1:0] tb, input logic tc);
    logic [W:0] full, gsum;
    logic       ep, eg;
    full = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
    gsum = {1'b0, ta} + {1'b0, tb};
    ep   = &(ta ^ tb);
    eg   = gsum[W];
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_lat%0d", tag, i), 64'(lat[i]), 64'(NCH[i]));
      chk($sformatf("%s_sum%0d", tag, i), 64'(sum_v[i]), 64'(full[W-1:0]));
      chk($sformatf("%s_cout%0d", tag, i), 64'(cout_v[i]), 64'(full[W]));
      chk($sformatf("%s_gp%0d", tag, i), 64'(gp_v[i]), 64'(ep));
      chk($sformatf("%s_gg%0d", tag, i), 64'(gg_v[i]), 64'(eg));
      chk($sformatf("%s_inv%0d", tag, i), 64'(cout_v[i]),
          64'(gg_v[i] | (gp_v[i] & tc)));
    end
  endtask

  task automatic chk_hand(input string tag, input logic [W-1:0] es, input logic ec,
                          input logic ep, input logic eg);
    chk({tag, "_sum"}, 64'(sum_v[1]), 64'(es));
    chk({tag, "_cout"}, 64'(cout_v[1]), 64'(ec));
    chk({tag, "_gp"}, 64'(gp_v[1]), 64'(ep));
    chk({tag, "_gg"}, 64'(gg_v[1]), 64'(eg));
    chk({tag, "_lat"}, 64'(lat[1]), 64'd8);
  endtask

  initial begin
    bit rose;
    logic [W-1:0] ra, rb;
    logic         rc;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_in_ready%0d", i), 64'(in_rdy[i]), 64'd1);
      chk($sformatf("rst_out_valid%0d", i), 64'(out_vld[i]), 64'd0);
      chk($sformatf("rst_busy%0d", i), 64'(busy_v[i]), 64'd0);
      chk($sformatf("rst_outs%0d", i),
          64'({sum_v[i], cout_v[i], gp_v[i], gg_v[i]}), 64'd0);
    end

    // Abort mid-run with reset
    start_op(32'h1234_5678, 32'h1111_1111, 1'b1);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_busy_pre", 64'(busy_v[1]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 64'(in_rdy[1]), 64'd1);
    chk("abort_busy", 64'(busy_v[1]), 64'd0);
    chk("abort_out_valid", 64'(out_vld[1]), 64'd0);
    chk("abort_outs", 64'({sum_v[1], cout_v[1], gp_v[1], gg_v[1]}), 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rose = 1'b0;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) if (out_vld[i]) rose = 1'b1;
    end
    chk("abort_no_valid", 64'(rose), 64'd0);

    // Full propagate
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    chk("acc_in_ready", 64'(in_rdy[1]), 64'd0);
    wait_done();
    chk_hand("fullprop", 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    check_res("fullprop", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    release_result();

    // MSB generate
    start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done();
    chk_hand("msbgen", 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    check_res("msbgen", 32'h8000_0000, 32'h8000_0000, 1'b0);
    release_result();

    // Mixed carries, then backpressure with in_valid held high
    start_op(32'h1234_5678, 32'h0FED_CBA9, 1'b0);
    wait_done();
    chk_hand("mixed", 32'h2222_2221, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    a = 32'h0000_0001; b = 32'h0000_0002; cin = 1'b1; in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("bp_in_ready%0d", c), 64'(in_rdy[1]), 64'd0);
      chk($sformatf("bp_out_valid%0d", c), 64'(out_vld[1]), 64'd1);
      chk($sformatf("bp_sum%0d", c), 64'(sum_v[1]), 64'h2222_2221);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_rel_out_valid%0d", i), 64'(out_vld[i]), 64'd0);
      chk($sformatf("bp_rel_in_ready%0d", i), 64'(in_rdy[i]), 64'd1);
      chk($sformatf("bp_rel_hold_sum%0d", i), 64'(sum_v[i]), 64'h2222_2221);
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_accept_busy", 64'(busy_v[1]), 64'd1);
    chk("bp_accept_in_ready", 64'(in_rdy[1]), 64'd0);
    wait_done();
    chk_hand("bp_next", 32'h0000_0004, 1'b0, 1'b0, 1'b0);
    check_res("bp_next", 32'h0000_0001, 32'h0000_0002, 1'b1);
    release_result();

    // Random regression
    for (int n = 0; n < 1000; n++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(1, 0));
      if (n % 8 == 0) rb = ~ra;
      start_op(ra, rb, rc);
      wait_done();
      check_res($sformatf("rnd%0d", n), ra, rb, rc);
      release_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
